// File: rtl/simple_processor_control_unit.sv
// Instruction sequencer for the 9-bit simple processor: captures IR from DIN and
// steps mv/mvi/add/sub through timesteps T0-T3, driving datapath enables and Bus selects.
module simple_processor_control_unit #(
  parameter int DATA_W = 9,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic              DINout,
  output logic              Gout,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done,
  output logic              Busy,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MVI = 3'b011;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [2:0]      opcode;
  logic [2:0]      reg_x;
  logic [2:0]      reg_y;
  logic [NREG-1:0] x_sel;
  logic [NREG-1:0] y_sel;
  logic            is_sub;

  assign opcode = ir_q[8:6];
  assign reg_x  = ir_q[5:3];
  assign reg_y  = ir_q[2:0];
  assign x_sel  = {{(NREG-1){1'b0}}, 1'b1} << reg_x;
  assign y_sel  = {{(NREG-1){1'b0}}, 1'b1} << reg_y;
  assign is_sub = (opcode == OP_SUB);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Every branch drives at most one Bus source and one Rin bit.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    DINout  = 1'b0;
    Gout    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      T0: begin
        IRin = Run;
        if (Run) begin
          ir_d    = DIN;
          state_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            Rout    = y_sel;
            Rin     = x_sel;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin     = x_sel;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout    = x_sel;
            Ain     = 1'b1;
            state_d = T2;
          end
          default: begin
            // Unassigned opcodes retire as a NOP.
            Done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        Rout    = y_sel;
        Gin     = 1'b1;
        AddSub  = is_sub;
        state_d = T3;
      end
      T3: begin
        Gout    = 1'b1;
        Rin     = x_sel;
        AddSub  = is_sub;
        Done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign Busy        = (state_q != T0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_simple_processor_control_unit.sv
// Directed bench for simple_processor_control_unit: hand-computed control vectors per timestep
// plus a per-cycle Bus-driver / Rin exclusivity monitor.
module tb_simple_processor_control_unit;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] DIN;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;
  logic       Busy;
  logic [1:0] dbg_state_o;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  simple_processor_control_unit #(.DATA_W(9), .NREG(8)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Run         (Run),
    .DIN         (DIN),
    .IRin        (IRin),
    .Rin         (Rin),
    .Rout        (Rout),
    .DINout      (DINout),
    .Gout        (Gout),
    .Ain         (Ain),
    .Gin         (Gin),
    .AddSub      (AddSub),
    .Done        (Done),
    .Busy        (Busy),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Busy}
  logic [23:0] obs;
  assign obs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Busy};

  function automatic logic [23:0] ctl(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                      input logic dinout, input logic gout, input logic ain,
                                      input logic gin, input logic addsub, input logic done,
                                      input logic busy);
    return {irin, rin, rout, dinout, gout, ain, gin, addsub, done, busy};
  endfunction

  task automatic chk(input string tag, input logic [23:0] observed, input logic [23:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %06h expected %06h", tag, observed, expected);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] expected);
    checks++;
    assert (dbg_state_o === expected)
    else begin
      errors++;
      $error("FAIL %s: observed state %0d expected %0d", tag, dbg_state_o, expected);
    end
  endtask

  // Outputs settle 2 time units after the edge; inputs are driven there too.
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  always @(negedge Clock) begin
    if (mon_en && Resetn) begin
      checks++;
      assert (($countones({Rout, DINout, Gout}) <= 1) && ($countones(Rin) <= 1))
      else begin
        errors++;
        $error("FAIL excl: observed bus=%03h rin=%02h expected onehot0", {Rout, DINout, Gout}, Rin);
      end
    end
  end

  initial begin
    // Reset with Run low: every output zero.
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 9'd0;
    #3;
    chk("reset_async", obs, 24'h0);
    tick();
    tick();
    chk("reset_held", obs, 24'h0);
    chk_state("reset_state", 2'd0);
    Resetn = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("idle_run0", obs, 24'h0);

    // mvi R0,#D
    Run = 1'b1;
    DIN = 9'b011000001;
    #1;
    chk("mvi_t0_irin", obs, ctl(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    DIN = 9'b111001111;
    Run = 1'b0;
    chk("mvi_t1", obs, ctl(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 1));
    chk_state("mvi_t1_state", 2'd1);
    tick();
    chk("mvi_back_t0", obs, 24'h0);

    // mv R5,R3
    Run = 1'b1;
    DIN = 9'b000101011;
    tick();
    Run = 1'b0;
    chk("mv_t1", obs, ctl(0, 8'h20, 8'h08, 0, 0, 0, 0, 0, 1, 1));
    tick();
    chk("mv_back_t0", obs, 24'h0);

    // sub R1,R6 with Run and DIN wiggled during T1-T3 (must be ignored)
    Run = 1'b1;
    DIN = 9'b010001110;
    tick();
    DIN = 9'b001111111;
    chk("sub_t1", obs, ctl(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 1));
    tick();
    Run = 1'b0;
    DIN = 9'b011111111;
    chk("sub_t2", obs, ctl(0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0, 1));
    chk_state("sub_t2_state", 2'd2);
    tick();
    chk("sub_t3", obs, ctl(0, 8'h02, 8'h00, 0, 1, 0, 0, 1, 1, 1));
    tick();
    chk("sub_back_t0", obs, 24'h0);

    // Back-to-back: mvi R2, add R2,R2, mvi R7 with Run held high.
    Run = 1'b1;
    DIN = 9'b011010000;
    tick();
    DIN = 9'h055;
    chk("b2b_mvi2_t1", obs, ctl(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1, 1));
    DIN = 9'b001010010;
    tick();
    chk("b2b_t0_a", obs, ctl(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("b2b_add_t1", obs, ctl(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 1));
    tick();
    chk("b2b_add_t2", obs, ctl(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 1));
    tick();
    chk("b2b_add_t3", obs, ctl(0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 1));
    DIN = 9'b011111000;
    tick();
    chk("b2b_t0_b", obs, ctl(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    DIN = 9'h1a5;
    Run = 1'b0;
    chk("b2b_mvi7_t1", obs, ctl(0, 8'h80, 8'h00, 1, 0, 0, 0, 0, 1, 1));
    tick();
    chk("b2b_back_t0", obs, 24'h0);

    // Illegal opcode retires as NOP.
    Run = 1'b1;
    DIN = 9'b101000000;
    tick();
    Run = 1'b0;
    chk("illegal_t1", obs, ctl(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tick();
    chk("illegal_back_t0", obs, 24'h0);
    tick();
    chk("idle_stays", obs, 24'h0);
    chk_state("idle_state", 2'd0);

    // Reset in T2 of add R3,R4 with Run held high, then restart.
    Run = 1'b1;
    DIN = 9'b001011100;
    tick();
    chk("rst_add_t1", obs, ctl(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 1));
    tick();
    chk("rst_add_t2", obs, ctl(0, 8'h00, 8'h10, 0, 0, 0, 1, 0, 0, 1));
    Resetn = 1'b0;
    #1;
    chk("rst_mid_t2", obs, ctl(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    chk_state("rst_mid_state", 2'd0);
    tick();
    chk("rst_held_run1", obs, ctl(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    Resetn = 1'b1;
    tick();
    chk("restart_t1", obs, ctl(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 1));
    Run = 1'b0;
    tick();
    chk("restart_t2", obs, ctl(0, 8'h00, 8'h10, 0, 0, 0, 1, 0, 0, 1));
    tick();
    chk("restart_t3", obs, ctl(0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1, 1));
    tick();
    chk("restart_back_t0", obs, 24'h0);

    // Final report
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_processor_control_unit.md
Name: simple_processor_control_unit

Overview:
- Sequencing FSM for the 9-bit simple processor datapath (R0-R7, A, G, adder/subtractor, shared Bus, DIN).
- Captures instructions from DIN into an internal IR when Run is high.
- Steps each instruction through timesteps T0-T3, driving register load enables, Bus mux selects, ALU controls and Done.
- Sits beside the datapath inside simple_processor_Top and replaces ad-hoc control logic.

Parameters:
- DATA_W, 9, instruction/data width; the encoding below is defined for 9 only.
- NREG, 8, number of general registers; width of the one-hot Rin/Rout vectors.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  DATA_W  instruction word (T0) or immediate data (mvi, T1).
- IRin  output  1  IR load strobe (exported for debug/trace).
- Rin  output  NREG  one-hot register load enables.
- Rout  output  NREG  one-hot register-to-Bus selects.
- DINout  output  1  DIN-to-Bus select.
- Gout  output  1  G-to-Bus select.
- Ain  output  1  A register load enable.
- Gin  output  1  G register load enable.
- AddSub  output  1  0 = add, 1 = subtract.
- Done  output  1  one-cycle pulse in the final timestep of an instruction.
- Busy  output  1  high in T1-T3.

Behaviour:
- Reset (Resetn=0, asynchronous): state=T0, IR=0.
  - All outputs derive combinationally from state, IR and Run, so with Run=0 every output is 0 during reset.
- IR format: IR[8:6]=opcode, IR[5:3]=X, IR[2:0]=Y.
  - Opcodes: 000 mv Rx,Ry; 001 add Rx,Ry; 010 sub Rx,Ry; 011 mvi Rx,#D.
  - Opcodes 100-111 are illegal and execute as a NOP.
- T0 (idle):
  - IRin=Run; IR<=DIN on the clock edge when Run=1; next=T1 if Run else T0.
  - All other outputs are 0.
- T1:
  - mv: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
  - mvi: DINout=1, Rin[X]=1, Done=1; next T0. The immediate must be on DIN during this cycle.
  - add/sub: Rout[X]=1, Ain=1; next T2.
  - illegal: Done=1, no enables; next T0.
- T2 (add/sub only): Rout[Y]=1, Gin=1, AddSub=(opcode==010); next T3.
- T3 (add/sub only): Gout=1, Rin[X]=1, AddSub held as in T2, Done=1; next T0.
- Latency:
  - mv/mvi/illegal: 2 cycles from the IR-load edge to completion.
  - add/sub: 4 cycles.
  - Back-to-back issue: a new instruction is accepted in the T0 directly following Done.
- Exclusivity:
  - At most one of {Rout[*], DINout, Gout} is high in any cycle (Bus single driver).
  - At most one bit of Rin is high.
- Run changes during T1-T3 are ignored; the instruction runs to completion.
- DIN changes outside T0 and mvi-T1 are ignored; IR is stable outside T0.
- X==Y (e.g. add R2,R2) is legal: T1 and T2 both select Rout[X].
- Reset mid-instruction: the FSM returns to T0 immediately, all enables drop and no Done is issued. The partially updated datapath state is not rolled back.
- Busy = (state != T0).
- No X/Z propagation on any output after reset.

Test Plan:
- Reset with Run=1 held: assert Resetn=0 mid-T2 of an add -> next sample state=T0 with Ain=Gin=Gout=Done=0 and Rin=Rout=0; after Resetn=1 the instruction restarts from T0.
- mvi R0: DIN=9'b011000001 with Run=1, then DIN=9'b111001111 -> T1 has DINout=1, Rin=8'b00000001, Done=1; T0 on the following cycle.
- mv R5,R3: DIN=9'b000101011 -> T1 has Rout=8'b00001000, Rin=8'b00100000, Done=1; no Ain/Gin/Gout.
- sub R1,R6: DIN=9'b010001110 -> controls as follows, Done high in T3 only:
  - T1: Rout=0x02, Ain=1.
  - T2: Rout=0x40, Gin=1, AddSub=1.
  - T3: Gout=1, Rin=0x02, AddSub=1.
- Back-to-back stream: mvi R2, add R2,R2, mvi R7 with Run=1 continuously -> Done pulses at cycles 2, 6 and 8 after the first IR load; Bus-driver exclusivity holds every cycle.
- Illegal opcode 9'b101000000: Done=1 in T1 with all enables 0, back to T0; Run=0 in T0 keeps the FSM idle with IRin=0.
